emu_scan_ctrl: RTL and testbench

- Sequences checkpoint dump and restore over the emulator's two scan chains: flip-flop (FF) and RAM.
- Accepts one host command at a time and asserts DUT halt for the whole operation.
- Drives the scan-enable, direction and data-in signals, and moves 64-bit beats between the chain and host-side valid/ready streams.
- Sits between the host/AXI front end and the $EMU_DUT scan ports.

---
 rtl/emu_scan_pkg.sv | 30 +++
 rtl/emu_scan_mux.sv | 59 +++++
 rtl/emu_scan_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_emu_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emu_scan_pkg.sv
// -----------------------------------------------------------------------------
// emu_scan_pkg
// Shared types and constants for the emulator checkpoint scan controller.
//   state_e : controller FSM states
//   cmd_t   : latched host command (operation + target chain)
//   OP_*    : operation encodings carried on cmd_op
//   TGT_*   : chain encodings carried on cmd_tgt
// -----------------------------------------------------------------------------
package emu_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DUMP = 3'd2,
    LOAD = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic OP_DUMP    = 1'b0;
  localparam logic OP_RESTORE = 1'b1;

  localparam logic TGT_FF  = 1'b0;
  localparam logic TGT_RAM = 1'b1;

  typedef struct packed {
    logic op;
    logic tgt;
  } cmd_t;

endpackage : emu_scan_pkg

// File: rtl/emu_scan_mux.sv
// -----------------------------------------------------------------------------
// emu_scan_mux
// Purely combinational steering between the controller and the two chains.
// The selected chain receives scan/dir/sdi; the other chain is held at
// scan=0, dir=0, sdi=0. The selected chain's head beat is returned on sel_sdo.
// Ports:
//   tgt                       : selected chain (TGT_FF / TGT_RAM)
//   scan_en, dir, sdi         : controller-side shift controls and data
//   sel_sdo                   : head beat of the selected chain
//   ff_scan/ff_dir/ff_sdi     : FF chain controls      ff_sdo  : FF head beat
//   ram_scan/ram_dir/ram_sdi  : RAM chain controls     ram_sdo : RAM head beat
// -----------------------------------------------------------------------------
module emu_scan_mux
  import emu_scan_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              tgt,
  input  logic              scan_en,
  input  logic              dir,
  input  logic [DATA_W-1:0] sdi,
  output logic [DATA_W-1:0] sel_sdo,

  output logic              ff_scan,
  output logic              ff_dir,
  output logic [DATA_W-1:0] ff_sdi,
  input  logic [DATA_W-1:0] ff_sdo,

  output logic              ram_scan,
  output logic              ram_dir,
  output logic [DATA_W-1:0] ram_sdi,
  input  logic [DATA_W-1:0] ram_sdo
);

  // Kept apart from the drive block so the sdo -> sdi rotate path in the
  // parent never looks like a loop through a single process.
  assign sel_sdo = (tgt == TGT_RAM) ? ram_sdo : ff_sdo;

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path
    // leaves a signal unassigned and no latch is inferred.
    ff_scan  = 1'b0;
    ff_dir   = 1'b0;
    ff_sdi   = '0;
    ram_scan = 1'b0;
    ram_dir  = 1'b0;
    ram_sdi  = '0;
    if (tgt == TGT_RAM) begin
      ram_scan = scan_en;
      ram_dir  = dir;
      ram_sdi  = sdi;
    end else begin
      ff_scan  = scan_en;
      ff_dir   = dir;
      ff_sdi   = sdi;
    end
  end

endmodule : emu_scan_mux

// File: rtl/emu_scan_ctrl.sv
// -----------------------------------------------------------------------------
// emu_scan_ctrl
// Checkpoint dump/restore sequencer for the emulator FF and RAM scan chains.
// One host command at a time: the DUT is halted, the chosen chain is shifted
// one beat per handshake, and done pulses for one cycle at the end.
// Dump rotates the chain (sdo fed back to sdi) so its contents survive.
// Ports:
//   clk, rst_n                    : emulator clock, async active-low reset
//   cmd_valid/cmd_ready           : command handshake (ready only when idle)
//   cmd_op, cmd_tgt               : 0=dump/1=restore, 0=FF/1=RAM
//   host_halt                     : user pause, ORed into halt
//   out_valid/ready/data/last     : dump beat stream to the host
//   in_valid/ready/data/last      : restore beat stream from the host
//   busy, done, err               : status (err = sticky in_last framing error)
//   halt                          : DUT freeze
//   ff_*/ram_*                    : scan enable, direction, data in/out
// -----------------------------------------------------------------------------
module emu_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int FF_BEATS  = 3,
  parameter int RAM_BEATS = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_tgt,
  input  logic              host_halt,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,

  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              halt,

  output logic              ff_scan,
  output logic              ff_dir,
  output logic [DATA_W-1:0] ff_sdi,
  input  logic [DATA_W-1:0] ff_sdo,

  output logic              ram_scan,
  output logic              ram_dir,
  output logic [DATA_W-1:0] ram_sdi,
  input  logic [DATA_W-1:0] ram_sdo
);

  localparam logic [CNT_W-1:0] FF_LAST  = CNT_W'(FF_BEATS - 1);
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_BEATS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  last_idx;
  logic              at_last;
  logic              out_hs;
  logic              in_hs;
  logic              scan_en;
  logic              dir;
  logic [DATA_W-1:0] sdi;
  logic [DATA_W-1:0] sel_sdo;

  assign last_idx = (cmd_q.tgt == TGT_RAM) ? RAM_LAST : FF_LAST;
  assign at_last  = (cnt_q == last_idx);
  assign out_hs   = (state_q == DUMP) && out_ready;
  assign in_hs    = (state_q == LOAD) && in_valid;

  // The chain only advances on a handshake, so a stall holds both the chain
  // position and the beat counter.
  assign scan_en  = out_hs || in_hs;
  assign dir      = (state_q == LOAD);

  always_comb begin
    sdi = '0;
    unique case (state_q)
      DUMP:    sdi = sel_sdo;   // circular rotate preserves the chain
      LOAD:    sdi = in_data;
      default: sdi = '0;
    endcase
  end

  emu_scan_mux #(
    .DATA_W (DATA_W)
  ) u_mux (
    .tgt      (cmd_q.tgt),
    .scan_en  (scan_en),
    .dir      (dir),
    .sdi      (sdi),
    .sel_sdo  (sel_sdo),
    .ff_scan  (ff_scan),
    .ff_dir   (ff_dir),
    .ff_sdi   (ff_sdi),
    .ff_sdo   (ff_sdo),
    .ram_scan (ram_scan),
    .ram_dir  (ram_dir),
    .ram_sdi  (ram_sdi),
    .ram_sdo  (ram_sdo)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q stays low for the first cycle after reset release.
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.op  = cmd_op;
          cmd_d.tgt = cmd_tgt;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = PREP;
        end
      end

      // One quiet cycle with halt up so the DUT is frozen before shifting.
      PREP: state_d = (cmd_q.op == OP_RESTORE) ? LOAD : DUMP;

      DUMP: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (at_last) state_d = FIN;
        end
      end

      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (at_last) begin
            // A full-length restore must end with in_last on its final beat.
            if (!in_last) err_d = 1'b1;
            state_d = FIN;
          end else if (in_last) begin
            // Early in_last: stop here, chain is left partially loaded.
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end

      FIN:     state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state's decode.
    done_d      = (state_d == FIN);
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign halt      = host_halt || busy_q;

  assign out_valid = (state_q == DUMP);
  assign out_data  = (state_q == DUMP) ? sel_sdo : '0;
  assign out_last  = (state_q == DUMP) && at_last;
  assign in_ready  = (state_q == LOAD);

endmodule : emu_scan_ctrl

// File: tb/tb_emu_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_emu_scan_ctrl
// Directed bench for emu_scan_ctrl with FF_BEATS=3, RAM_BEATS=4. Both scan
// chains are modelled as shift registers whose head beat drives sdo.
// -----------------------------------------------------------------------------
module tb_emu_scan_ctrl;

  localparam int DATA_W = 64;

  localparam logic [63:0] VA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] VB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] VC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] R0 = 64'hDEAD_0000_0000_0000;
  localparam logic [63:0] V11 = 64'h0000_0000_0000_0011;
  localparam logic [63:0] V22 = 64'h0000_0000_0000_0022;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_op, cmd_tgt, host_halt;
  logic              cmd_ready;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic              busy, done, err, halt;
  logic              ff_scan, ff_dir, ram_scan, ram_dir;
  logic [DATA_W-1:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  emu_scan_ctrl #(
    .DATA_W    (DATA_W),
    .FF_BEATS  (3),
    .RAM_BEATS (4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_tgt   (cmd_tgt),
    .host_halt (host_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .halt      (halt),
    .ff_scan   (ff_scan),
    .ff_dir    (ff_dir),
    .ff_sdi    (ff_sdi),
    .ff_sdo    (ff_sdo),
    .ram_scan  (ram_scan),
    .ram_dir   (ram_dir),
    .ram_sdi   (ram_sdi),
    .ram_sdo   (ram_sdo)
  );

  // Chain models: index 0 is the head beat; a scan edge shifts toward the head
  // and inserts sdi at the tail. Chains are not touched by reset.
  logic [63:0] ff_chain  [3] = '{VA, VB, VC};
  logic [63:0] ram_chain [4] = '{R0, R0, R0, R0};
  int          ff_scan_cnt = 0;

  assign ff_sdo  = ff_chain[0];
  assign ram_sdo = ram_chain[0];

  always @(posedge clk) begin
    if (ff_scan) begin
      for (int i = 0; i < 2; i++) ff_chain[i] <= ff_chain[i+1];
      ff_chain[2] <= ff_sdi;
      ff_scan_cnt <= ff_scan_cnt + 1;
    end
    if (ram_scan) begin
      for (int i = 0; i < 3; i++) ram_chain[i] <= ram_chain[i+1];
      ram_chain[3] <= ram_sdi;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DUMP cycle: beat content, last flag and chain steering.
  task automatic dump_beat(input string tag, input logic [63:0] d, input logic last,
                           input logic ram);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " out_data"},  out_data, d);
    check({tag, " out_last"},  64'(out_last), 64'(last));
    if (ram) begin
      check({tag, " ram_scan"}, 64'(ram_scan), 64'(out_ready));
      check({tag, " ram_sdi"},  ram_sdi, d);
      check({tag, " ff_scan"},  64'(ff_scan), 64'd0);
    end else begin
      check({tag, " ff_scan"},  64'(ff_scan), 64'(out_ready));
      check({tag, " ff_dir"},   64'(ff_dir), 64'd0);
      check({tag, " ff_sdi"},   ff_sdi, d);
      check({tag, " ram_scan"}, 64'(ram_scan), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int scan_before;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_tgt   = 1'b0;
    host_halt = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst busy",      64'(busy), 64'd0);
    check("rst done",      64'(done), 64'd0);
    check("rst err",       64'(err), 64'd0);
    check("rst halt",      64'(halt), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready",  64'(in_ready), 64'd0);
    check("rst ff_scan",   64'(ff_scan), 64'd0);
    check("rst ram_scan",  64'(ram_scan), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle cmd_ready", 64'(cmd_ready), 64'd1);

    // ---------------- 1: dump FF, no stalls ----------------
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tgt = 1'b0; out_ready = 1'b1;
    tick();                                     // accept edge
    cmd_valid = 1'b0;
    check("d1 prep halt",      64'(halt), 64'd1);
    check("d1 prep busy",      64'(busy), 64'd1);
    check("d1 prep cmd_ready", 64'(cmd_ready), 64'd0);
    check("d1 prep out_valid", 64'(out_valid), 64'd0);
    check("d1 prep ff_scan",   64'(ff_scan), 64'd0);
    tick();
    dump_beat("d1 b0", VA, 1'b0, 1'b0);
    check("d1 b0 halt", 64'(halt), 64'd1);
    tick();
    dump_beat("d1 b1", VB, 1'b0, 1'b0);
    tick();
    dump_beat("d1 b2", VC, 1'b1, 1'b0);
    check("d1 b2 halt", 64'(halt), 64'd1);
    tick();                                     // cycle 5 after accept
    check("d1 fin done",      64'(done), 64'd1);
    check("d1 fin halt",      64'(halt), 64'd1);
    check("d1 fin ff_scan",   64'(ff_scan), 64'd0);
    check("d1 fin out_valid", 64'(out_valid), 64'd0);
    tick();
    check("d1 idle done",      64'(done), 64'd0);
    check("d1 idle halt",      64'(halt), 64'd0);
    check("d1 idle busy",      64'(busy), 64'd0);
    check("d1 idle cmd_ready", 64'(cmd_ready), 64'd1);
    check("d1 chain0", ff_chain[0], VA);
    check("d1 chain1", ff_chain[1], VB);
    check("d1 chain2", ff_chain[2], VC);

    // ---------------- 2: dump FF with out_ready 1,0,0,1,1 ----------------
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tgt = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();                                     // into DUMP
    out_ready = 1'b1; #1; dump_beat("d2 c0", VA, 1'b0, 1'b0); tick();
    out_ready = 1'b0; #1; dump_beat("d2 c1", VB, 1'b0, 1'b0); tick();
    out_ready = 1'b0; #1; dump_beat("d2 c2", VB, 1'b0, 1'b0); tick();
    out_ready = 1'b1; #1; dump_beat("d2 c3", VB, 1'b0, 1'b0); tick();
    out_ready = 1'b1; #1; dump_beat("d2 c4", VC, 1'b1, 1'b0); tick();
    check("d2 fin done", 64'(done), 64'd1);
    tick();
    check("d2 chain0", ff_chain[0], VA);
    check("d2 chain1", ff_chain[1], VB);
    check("d2 chain2", ff_chain[2], VC);

    // ---------------- 3: restore RAM 1,2,3,4 ----------------
    scan_before = ff_scan_cnt;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tgt = 1'b1; out_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("r3 prep in_ready", 64'(in_ready), 64'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_last = (i == 4);
      #1;
      check("r3 in_ready", 64'(in_ready), 64'd1);
      check("r3 ram_scan", 64'(ram_scan), 64'd1);
      check("r3 ram_dir",  64'(ram_dir), 64'd1);
      check("r3 ram_sdi",  ram_sdi, 64'(i));
      check("r3 ff_scan",  64'(ff_scan), 64'd0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("r3 fin done", 64'(done), 64'd1);
    check("r3 fin err",  64'(err), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) check("r3 ram chain", ram_chain[i], 64'(i + 1));
    check("r3 ff_scan never", 64'(ff_scan_cnt - scan_before), 64'd0);

    // ---------------- 4: restore FF, early in_last on beat 2 ----------------
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tgt = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = V11; in_last = 1'b0; #1;
    check("r4 b0 ff_scan", 64'(ff_scan), 64'd1);
    check("r4 b0 ff_dir",  64'(ff_dir), 64'd1);
    check("r4 b0 ff_sdi",  ff_sdi, V11);
    tick();
    in_data = V22; in_last = 1'b1; #1;
    check("r4 b1 ff_scan", 64'(ff_scan), 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0; #1;
    check("r4 fin done",     64'(done), 64'd1);
    check("r4 fin err",      64'(err), 64'd1);
    check("r4 fin in_ready", 64'(in_ready), 64'd0);
    tick();
    check("r4 idle err sticky", 64'(err), 64'd1);
    check("r4 idle done",       64'(done), 64'd0);

    // ---------------- 5: dump RAM with host_halt held ----------------
    host_halt = 1'b1; #1;
    check("h5 idle halt", 64'(halt), 64'd1);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tgt = 1'b1; out_ready = 1'b1;
    tick();
    check("h5 err cleared", 64'(err), 64'd0);
    check("h5 prep cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      cmd_valid = i[0];
      #1;
      dump_beat("h5 beat", 64'(i), (i == 4), 1'b1);
      check("h5 cmd_ready busy", 64'(cmd_ready), 64'd0);
      tick();
    end
    cmd_valid = 1'b0; #1;
    check("h5 fin done", 64'(done), 64'd1);
    tick();
    check("h5 idle halt", 64'(halt), 64'd1);
    check("h5 idle busy", 64'(busy), 64'd0);
    host_halt = 1'b0; #1;
    check("h5 halt drop", 64'(halt), 64'd0);

    // ---------------- 6: async reset during LOAD beat 1 ----------------
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tgt = 1'b0; out_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 64'h55; #1;
    check("x6 load ff_scan", 64'(ff_scan), 64'd1);
    rst_n = 1'b0; #1;
    check("x6 rst ff_scan",   64'(ff_scan), 64'd0);
    check("x6 rst ff_dir",    64'(ff_dir), 64'd0);
    check("x6 rst ff_sdi",    ff_sdi, 64'd0);
    check("x6 rst halt",      64'(halt), 64'd0);
    check("x6 rst busy",      64'(busy), 64'd0);
    check("x6 rst in_ready",  64'(in_ready), 64'd0);
    check("x6 rst cmd_ready", 64'(cmd_ready), 64'd0);
    check("x6 rst done",      64'(done), 64'd0);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("x6 idle cmd_ready", 64'(cmd_ready), 64'd1);
    check("x6 idle done",      64'(done), 64'd0);
    // FF chain still holds C,11,22 from the partial restore in test 4.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tgt = 1'b0; out_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    dump_beat("x6 b0", VC, 1'b0, 1'b0);  tick();
    dump_beat("x6 b1", V11, 1'b0, 1'b0); tick();
    dump_beat("x6 b2", V22, 1'b1, 1'b0); tick();
    check("x6 fin done", 64'(done), 64'd1);
    tick();
    check("x6 chain0", ff_chain[0], VC);
    check("x6 chain2", ff_chain[2], V22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_emu_scan_ctrl
